stopwatch_ctrl: RTL and testbench

//  Control FSM for a chained BCD-counter stopwatch display (hundredths .. minutes).
//  - Takes two debounced push-button levels: start/stop and lap/clear.
//  - Derives the count-enable tick from the 50 MHz clock and drives the chain's clken/reset/freeze.
//  - Sits between the button debouncers and the lowest bcd digit; the top digit's carry feeds back for overflow.

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_ctrl_if.sv | 26 ++
 rtl/btn_edge.sv | 29 ++
 rtl/stopwatch_ctrl.sv | 122 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control slice.
package stopwatch_pkg;

  localparam int unsigned CLK_HZ_DEFAULT  = 50_000_000;
  localparam int unsigned TICK_HZ_DEFAULT = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } sw_state_e;

  // States in which the prescaler advances and the digits see clken.
  function automatic logic is_counting(input sw_state_e s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button, carry and digit-chain control signals of the stopwatch controller.
interface stopwatch_ctrl_if;

  logic                   btn_ss;
  logic                   btn_lap;
  logic                   carry_top;
  logic                   tick_en;
  logic                   cnt_reset;
  logic                   freeze;
  logic                   running;
  logic                   overflow;
  stopwatch_pkg::sw_state_e state;

  // Controller side: takes buttons and carry, drives the digit chain.
  modport master (
    input  btn_ss, btn_lap, carry_top,
    output tick_en, cnt_reset, freeze, running, overflow, state
  );

  // Environment side: debouncers, digit chain and display.
  modport slave (
    output btn_ss, btn_lap, carry_top,
    input  tick_en, cnt_reset, freeze, running, overflow, state
  );

endinterface

// File: rtl/btn_edge.sv
// Two-flop synchroniser plus rising-edge detector for one button level.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic ev_c
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronise the asynchronous level and keep one stage of history.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= level;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // One-clock pulse on the synchronised rising edge; a held button fires once.
  assign ev_c = sync2_q & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button events, count prescaler and digit-chain control.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int unsigned TICK_HZ = TICK_HZ_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  stopwatch_ctrl_if.master sw
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;

  // A prescaler shorter than two clocks cannot produce a pulsed clken.
  if (DIV < 2) begin : g_div_check
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic          ss_ev_c;
  logic          lap_ev_c;
  logic          counting_c;
  logic          wrap_c;

  sw_state_e     state_q;
  logic [PW-1:0] presc_q;
  logic          tick_en_q;
  logic          cnt_reset_q;
  logic          freeze_q;
  logic          running_q;
  logic          overflow_q;

  btn_edge u_ss_edge (
    .clk   (clk),
    .reset (reset),
    .level (sw.btn_ss),
    .ev_c  (ss_ev_c)
  );

  btn_edge u_lap_edge (
    .clk   (clk),
    .reset (reset),
    .level (sw.btn_lap),
    .ev_c  (lap_ev_c)
  );

  assign counting_c = is_counting(state_q);
  assign wrap_c     = (presc_q == PW'(DIV - 1));

  // State, prescaler and all registered outputs; outputs move with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      tick_en_q   <= 1'b0;
      cnt_reset_q <= 1'b1;
      freeze_q    <= 1'b0;
      running_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      // Wrap decided on the current state, so a tick coinciding with a stop is kept.
      tick_en_q   <= counting_c && wrap_c;
      cnt_reset_q <= 1'b0;

      if (counting_c) begin
        presc_q <= wrap_c ? '0 : presc_q + PW'(1);
      end else if (state_q == IDLE) begin
        presc_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (ss_ev_c) begin
            state_q   <= RUN;
            running_q <= 1'b1;
            freeze_q  <= 1'b0;
          end
        end
        RUN, LAP: begin
          if (sw.carry_top) begin
            state_q    <= STOP;
            overflow_q <= 1'b1;
            running_q  <= 1'b0;
            freeze_q   <= 1'b0;
          end else if (ss_ev_c) begin
            state_q   <= STOP;
            running_q <= 1'b0;
            freeze_q  <= 1'b0;
          end else if (lap_ev_c) begin
            state_q  <= (state_q == RUN) ? LAP : RUN;
            freeze_q <= (state_q == RUN);
          end
        end
        STOP: begin
          if (ss_ev_c) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else if (lap_ev_c) begin
            state_q     <= IDLE;
            cnt_reset_q <= 1'b1;
            overflow_q  <= 1'b0;
            presc_q     <= '0;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          freeze_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sw.tick_en   = tick_en_q;
  assign sw.cnt_reset = cnt_reset_q;
  assign sw.freeze    = freeze_q;
  assign sw.running   = running_q;
  assign sw.overflow  = overflow_q;
  assign sw.state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl at CLK_HZ=1000, TICK_HZ=100.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int unsigned DIV = 10;

  typedef struct {
    sw_state_e   st;
    logic        fr;
    logic        rn;
    logic        ov;
    int unsigned cyc;
  } exp_t;

  logic clk;
  logic reset;
  int unsigned cyc;
  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned ticks_seen;
  bit          mon_en;
  logic [4:0]  prev_snap;

  exp_t        sq[$];
  int unsigned tq[$];
  int unsigned ph;
  int unsigned run_edge;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .CLK_HZ  (1000),
    .TICK_HZ (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_state(input sw_state_e st, input logic fr, input logic rn,
                              input logic ov, input int unsigned at);
    exp_t e;
    e.st = st; e.fr = fr; e.rn = rn; e.ov = ov; e.cyc = at;
    sq.push_back(e);
  endtask

  // Counting resumes at edge r with held phase ph: wraps at r+(DIV-ph)+k*DIV.
  task automatic start_count(input int unsigned r);
    run_edge = r;
    for (int k = 0; k < 40; k++) tq.push_back(r + (DIV - ph) + 32'(k) * DIV);
  endtask

  // Counting ends at edge s (that edge still counts); drop later ticks.
  task automatic stop_count(input int unsigned s);
    ph = (ph + s - run_edge) % DIV;
    while (tq.size() > 0 && tq[$] > s) void'(tq.pop_back());
    chk("ticks_before_stop", tq.size(), 0);
  endtask

  // Monitor: pops expected ticks and state changes as the DUT produces them.
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] snap;
    int unsigned exp_cyc;
    if (mon_en) begin
      if (sw_if.tick_en === 1'b1) begin
        ticks_seen++;
        chk("tick_expected", 32'(tq.size() > 0), 1);
        if (tq.size() > 0) begin
          exp_cyc = tq.pop_front();
          chk("tick_cycle", cyc, exp_cyc);
        end
      end
      snap = {sw_if.state, sw_if.freeze, sw_if.running, sw_if.overflow};
      if (snap !== prev_snap) begin
        chk("state_change_expected", 32'(sq.size() > 0), 1);
        if (sq.size() > 0) begin
          e = sq.pop_front();
          chk("sb_state", 32'(sw_if.state), 32'(e.st));
          chk("sb_freeze", 32'(sw_if.freeze), 32'(e.fr));
          chk("sb_running", 32'(sw_if.running), 32'(e.rn));
          chk("sb_overflow", 32'(sw_if.overflow), 32'(e.ov));
          chk("sb_cycle", cyc, e.cyc);
        end
        prev_snap = snap;
      end
    end
  end

  initial begin
    int unsigned c;
    int unsigned t0;
    int d;
    n_tests = 0; n_fail = 0; ticks_seen = 0; cyc = 0; ph = 0; run_edge = 0;
    mon_en = 1'b0; prev_snap = '0;
    reset = 1'b1;
    sw_if.btn_ss = 1'b0; sw_if.btn_lap = 1'b0; sw_if.carry_top = 1'b0;

    // Reset for three clocks.
    wait_clk(3);
    reset = 1'b0;
    chk("rst_cnt_reset", 32'(sw_if.cnt_reset), 1);
    chk("rst_state", 32'(sw_if.state), 32'(IDLE));
    chk("rst_tick_en", 32'(sw_if.tick_en), 0);
    chk("rst_freeze", 32'(sw_if.freeze), 0);
    chk("rst_running", 32'(sw_if.running), 0);
    chk("rst_overflow", 32'(sw_if.overflow), 0);
    prev_snap = {sw_if.state, sw_if.freeze, sw_if.running, sw_if.overflow};
    mon_en = 1'b1;
    wait_clk(1);
    chk("cnt_reset_release", 32'(sw_if.cnt_reset), 0);
    wait_clk(100);
    chk("idle_no_tick", ticks_seen, 0);
    chk("idle_state", 32'(sw_if.state), 32'(IDLE));

    // IDLE -> RUN with a 5-clock press; latency 3 edges, one event only.
    c = cyc;
    expect_state(RUN, 1'b0, 1'b1, 1'b0, c + 3);
    start_count(c + 3);
    sw_if.btn_ss = 1'b1;
    wait_clk(2);
    chk("ss_latency_before", 32'(sw_if.state), 32'(IDLE));
    wait_clk(1);
    chk("ss_latency_at", 32'(sw_if.state), 32'(RUN));
    wait_clk(2);
    sw_if.btn_ss = 1'b0;
    wait_clk(25);
    chk("run_ticks", ticks_seen, 2);

    // RUN -> LAP: freeze set, ticks continue.
    c = cyc;
    expect_state(LAP, 1'b1, 1'b1, 1'b0, c + 3);
    sw_if.btn_lap = 1'b1;
    wait_clk(3);
    chk("lap_freeze", 32'(sw_if.freeze), 1);
    sw_if.btn_lap = 1'b0;
    t0 = ticks_seen;
    wait_clk(20);
    chk("lap_ticks", ticks_seen - t0, 2);

    // LAP -> RUN: freeze released.
    c = cyc;
    expect_state(RUN, 1'b0, 1'b1, 1'b0, c + 3);
    sw_if.btn_lap = 1'b1;
    wait_clk(3);
    sw_if.btn_lap = 1'b0;
    chk("unlap_freeze", 32'(sw_if.freeze), 0);
    wait_clk(10);

    // Stop 4 clocks into a tick period.
    d = int'(tq[0]) - 6 - 3 - int'(cyc);
    if (d < 0) d += int'(DIV);
    wait_clk(d);
    c = cyc;
    expect_state(STOP, 1'b0, 1'b0, 1'b0, c + 3);
    sw_if.btn_ss = 1'b1;
    wait_clk(3);
    sw_if.btn_ss = 1'b0;
    stop_count(c + 3);
    t0 = ticks_seen;
    wait_clk(30);
    chk("stop_no_tick", ticks_seen - t0, 0);

    // Resume: the next tick comes after the remaining 6 clocks.
    c = cyc;
    expect_state(RUN, 1'b0, 1'b1, 1'b0, c + 3);
    start_count(c + 3);
    sw_if.btn_ss = 1'b1;
    wait_clk(3);
    wait_clk(5);
    chk("resume_tick_early", 32'(sw_if.tick_en), 0);
    wait_clk(1);
    chk("resume_tick_at6", 32'(sw_if.tick_en), 1);
    sw_if.btn_ss = 1'b0;
    wait_clk(4);

    // Stop on the exact wrap edge: that tick is still issued.
    d = int'(tq[0]) - 3 - int'(cyc);
    if (d < 0) d += int'(DIV);
    wait_clk(d);
    c = cyc;
    expect_state(STOP, 1'b0, 1'b0, 1'b0, c + 3);
    sw_if.btn_ss = 1'b1;
    wait_clk(3);
    chk("inflight_tick", 32'(sw_if.tick_en), 1);
    sw_if.btn_ss = 1'b0;
    stop_count(c + 3);
    wait_clk(5);

    // STOP -> IDLE via lap: one-clock cnt_reset.
    c = cyc;
    expect_state(IDLE, 1'b0, 1'b0, 1'b0, c + 3);
    sw_if.btn_lap = 1'b1;
    wait_clk(2);
    chk("clear_cnt_reset_before", 32'(sw_if.cnt_reset), 0);
    wait_clk(1);
    chk("clear_cnt_reset", 32'(sw_if.cnt_reset), 1);
    wait_clk(1);
    chk("clear_cnt_reset_after", 32'(sw_if.cnt_reset), 0);
    sw_if.btn_lap = 1'b0;
    ph = 0;
    wait_clk(5);

    // IDLE -> RUN, then both buttons in the same clock: start/stop wins.
    c = cyc;
    expect_state(RUN, 1'b0, 1'b1, 1'b0, c + 3);
    start_count(c + 3);
    sw_if.btn_ss = 1'b1;
    wait_clk(4);
    sw_if.btn_ss = 1'b0;
    wait_clk(12);
    c = cyc;
    expect_state(STOP, 1'b0, 1'b0, 1'b0, c + 3);
    sw_if.btn_ss = 1'b1;
    sw_if.btn_lap = 1'b1;
    wait_clk(3);
    chk("both_state", 32'(sw_if.state), 32'(STOP));
    chk("both_freeze", 32'(sw_if.freeze), 0);
    sw_if.btn_ss = 1'b0;
    sw_if.btn_lap = 1'b0;
    stop_count(c + 3);
    wait_clk(5);

    // STOP -> RUN, then carry_top forces STOP with overflow on the same edge.
    c = cyc;
    expect_state(RUN, 1'b0, 1'b1, 1'b0, c + 3);
    start_count(c + 3);
    sw_if.btn_ss = 1'b1;
    wait_clk(3);
    sw_if.btn_ss = 1'b0;
    wait_clk(7);
    c = cyc;
    expect_state(STOP, 1'b0, 1'b0, 1'b1, c + 1);
    sw_if.carry_top = 1'b1;
    wait_clk(1);
    sw_if.carry_top = 1'b0;
    chk("carry_state", 32'(sw_if.state), 32'(STOP));
    chk("carry_overflow", 32'(sw_if.overflow), 1);
    stop_count(c + 1);
    wait_clk(3);
    c = cyc;
    expect_state(RUN, 1'b0, 1'b1, 1'b1, c + 3);
    start_count(c + 3);
    sw_if.btn_ss = 1'b1;
    wait_clk(3);
    sw_if.btn_ss = 1'b0;
    chk("resume_overflow_sticky", 32'(sw_if.overflow), 1);
    wait_clk(12);

    // Stop, then carry in STOP is ignored; lap clears overflow.
    c = cyc;
    expect_state(STOP, 1'b0, 1'b0, 1'b1, c + 3);
    sw_if.btn_ss = 1'b1;
    wait_clk(3);
    sw_if.btn_ss = 1'b0;
    stop_count(c + 3);
    sw_if.carry_top = 1'b1;
    wait_clk(1);
    sw_if.carry_top = 1'b0;
    wait_clk(2);
    chk("stop_carry_ignored", 32'(sw_if.state), 32'(STOP));
    c = cyc;
    expect_state(IDLE, 1'b0, 1'b0, 1'b0, c + 3);
    sw_if.btn_lap = 1'b1;
    wait_clk(3);
    sw_if.btn_lap = 1'b0;
    chk("clear_overflow", 32'(sw_if.overflow), 0);
    ph = 0;

    // Carry in IDLE is ignored.
    sw_if.carry_top = 1'b1;
    wait_clk(1);
    sw_if.carry_top = 1'b0;
    wait_clk(2);
    chk("idle_carry_overflow", 32'(sw_if.overflow), 0);

    // Reset mid-run: back to IDLE immediately, digits cleared, no tick.
    c = cyc;
    expect_state(RUN, 1'b0, 1'b1, 1'b0, c + 3);
    start_count(c + 3);
    sw_if.btn_ss = 1'b1;
    wait_clk(3);
    sw_if.btn_ss = 1'b0;
    wait_clk(13);
    c = cyc;
    expect_state(IDLE, 1'b0, 1'b0, 1'b0, c + 1);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    chk("midrst_cnt_reset", 32'(sw_if.cnt_reset), 1);
    chk("midrst_tick_en", 32'(sw_if.tick_en), 0);
    stop_count(c);
    ph = 0;
    t0 = ticks_seen;
    wait_clk(20);
    chk("midrst_no_tick", ticks_seen - t0, 0);
    chk("midrst_state", 32'(sw_if.state), 32'(IDLE));

    chk("sb_state_drained", sq.size(), 0);
    chk("sb_tick_drained", tq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
